// File: rtl/master_req_ctrl.sv
// master_req_ctrl: per-master request controller. Captures one transaction, waits for
// the targeted slave's ack (and read response), then returns a one-cycle completion.
`default_nettype none

module master_req_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_req,
  input  logic              m_cmd,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_ack,
  output logic              m_err,
  output logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        req_stat,
  output logic              sfor,
  output logic              s_cmd,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              ack_s0,
  input  logic              ack_s1,
  input  logic              resp_s0,
  input  logic              resp_s1,
  input  logic [DATA_W-1:0] rdata_s0,
  input  logic [DATA_W-1:0] rdata_s1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    W_RESP = 2'd1,
    W_ACK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic             C_TO_EN   = (TIMEOUT != 0);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                w_ack_nxt, w_err_nxt, w_cap;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                w_sel_ack, w_sel_resp, w_expire;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic [CNT_W-1:0]    w_cnt_inc;

  assign w_sel_ack   = sfor ? ack_s1   : ack_s0;
  assign w_sel_resp  = sfor ? resp_s1  : resp_s0;
  assign w_sel_rdata = sfor ? rdata_s1 : rdata_s0;
  assign w_expire    = C_TO_EN && (r_cnt == C_TO_LAST);
  // Saturating increment: the counter must never wrap back into the live range.
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign req_stat    = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = m_rdata;
    w_cap       = 1'b0;
    case (r_state)
      IDLE: begin
        if (m_req) begin
          w_cap       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = W_ACK;
        end
      end
      W_ACK: begin
        if (w_sel_ack) begin
          if (s_cmd) begin
            w_state_nxt = DONE;
            w_ack_nxt   = 1'b1;
            w_rdata_nxt = '0;
          end else begin
            w_state_nxt = W_RESP;
            w_cnt_nxt   = '0;
          end
        end else if (w_expire) begin
          w_state_nxt = DONE;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      W_RESP: begin
        if (w_sel_resp) begin
          w_state_nxt = DONE;
          w_ack_nxt   = 1'b1;
          w_rdata_nxt = w_sel_rdata;
        end else if (w_expire) begin
          w_state_nxt = DONE;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
      sfor    <= 1'b0;
      s_cmd   <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      m_ack   <= w_ack_nxt;
      m_err   <= w_err_nxt;
      m_rdata <= w_rdata_nxt;
      if (w_cap) begin
        sfor    <= m_addr[ADDR_W-1];
        s_cmd   <= m_cmd;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_master_req_ctrl.sv
// Randomized scoreboard bench for master_req_ctrl with a transaction-level timing model.
`default_nettype none

module tb_master_req_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m_req = 1'b0, m_cmd = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_ack, m_err, sfor, s_cmd;
  logic [31:0] m_rdata, s_addr, s_wdata;
  logic [1:0]  req_stat;
  logic        ack_s0 = 1'b0, ack_s1 = 1'b0, resp_s0 = 1'b0, resp_s1 = 1'b0;
  logic [31:0] rdata_s0 = '0, rdata_s1 = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  master_req_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .req_stat(req_stat), .sfor(sfor), .s_cmd(s_cmd), .s_addr(s_addr),
    .s_wdata(s_wdata), .ack_s0(ack_s0), .ack_s1(ack_s1), .resp_s0(resp_s0),
    .resp_s1(resp_s1), .rdata_s0(rdata_s0), .rdata_s1(rdata_s1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && m_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 64'(m_ack), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_stat", 64'(req_stat), 64'd3);
        chk("m_err", 64'(m_err), 64'(e.err));
        if (e.chk_rd) chk("m_rdata", 64'(m_rdata), 64'(e.rdata));
      end
    end
  end

  task automatic clr_slv();
    ack_s0 = 0; ack_s1 = 0; resp_s0 = 0; resp_s1 = 0;
    rdata_s0 = $urandom; rdata_s1 = $urandom;
  endtask

  // noise: 0 quiet, 1 random junk on ignored lines, 2 wrong slave asserted throughout
  task automatic do_txn(input logic cmd, input logic [31:0] addr, input logic [31:0] wdata,
                        input int k, input int j, input logic [31:0] rd,
                        input int noise, input bit hold);
    exp_t e;
    logic sel;
    bit   acked;
    int   kend, jend;
    sel   = addr[31];
    acked = (k <= TO);
    kend  = acked ? k : TO;
    jend  = (j <= TO) ? j : TO;
    e.err    = !acked || (!cmd && j > TO);
    e.chk_rd = !cmd || e.err;
    e.rdata  = e.err ? 32'd0 : rd;
    exp_q.push_back(e);

    @(negedge clk);
    m_req = 1; m_cmd = cmd; m_addr = addr; m_wdata = wdata;
    @(posedge clk); #1;
    chk("cap_stat", 64'(req_stat), 64'd2);
    chk("cap_sfor", 64'(sfor), 64'(sel));
    chk("cap_cmd", 64'(s_cmd), 64'(cmd));
    chk("cap_addr", 64'(s_addr), 64'(addr));
    chk("cap_wdata", 64'(s_wdata), 64'(wdata));

    for (int c = 1; c <= kend; c++) begin
      @(negedge clk);
      clr_slv();
      if (!hold) m_req = (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise == 1) {ack_s0, ack_s1, resp_s0, resp_s1} = 4'($urandom);
      if (noise == 2) begin
        if (sel) begin ack_s0 = 1; resp_s0 = 1; end
        else begin ack_s1 = 1; resp_s1 = 1; end
      end
      if (sel) ack_s1 = (c == k); else ack_s0 = (c == k);
      @(posedge clk); #1;
      if (c < kend) chk("wack_stat", 64'(req_stat), 64'd2);
    end

    if (acked && !cmd) begin
      chk("wresp_entry", 64'(req_stat), 64'd1);
      for (int c = 1; c <= jend; c++) begin
        @(negedge clk);
        clr_slv();
        if (!hold) m_req = (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise == 1) {ack_s0, ack_s1, resp_s0, resp_s1} = 4'($urandom);
        if (noise == 2) begin
          if (sel) resp_s0 = 1; else resp_s1 = 1;
        end
        if (sel) begin
          resp_s1 = (c == j);
          if (c == j) rdata_s1 = rd;
        end else begin
          resp_s0 = (c == j);
          if (c == j) rdata_s0 = rd;
        end
        @(posedge clk); #1;
        if (c < jend) chk("wresp_stat", 64'(req_stat), 64'd1);
      end
    end

    chk("done_entry", 64'(req_stat), 64'd3);
    chk("done_ack", 64'(m_ack), 64'd1);
    @(negedge clk);
    clr_slv();
    m_req = hold;
    @(posedge clk); #1;
    chk("idle_stat", 64'(req_stat), 64'd0);
    chk("idle_ack", 64'(m_ack), 64'd0);
  endtask

  task automatic reset_in_wresp();
    @(negedge clk);
    m_req = 1; m_cmd = 0; m_addr = 32'h8000_0100; m_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    m_req = 0; ack_s1 = 1;
    @(posedge clk); #1;
    chk("rst_pre_stat", 64'(req_stat), 64'd1);
    #2 reset = 0;
    #1;
    chk("rst_stat", 64'(req_stat), 64'd0);
    chk("rst_sfor", 64'(sfor), 64'd0);
    chk("rst_addr", 64'(s_addr), 64'd0);
    chk("rst_wdata", 64'(s_wdata), 64'd0);
    chk("rst_outs", 64'({m_ack, m_err, s_cmd}), 64'd0);
    chk("rst_rdata", 64'(m_rdata), 64'd0);
    ack_s1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      resp_s1 = c[0]; resp_s0 = ~c[0]; ack_s1 = c[0];
      rdata_s1 = $urandom;
    end
    @(negedge clk);
    clr_slv();
    @(posedge clk); #1;
    chk("rst_after_stat", 64'(req_stat), 64'd0);
  endtask

  initial begin
    #1;
    chk("reset_stat", 64'(req_stat), 64'd0);
    chk("reset_outs", 64'({m_ack, m_err, sfor, s_cmd}), 64'd0);
    chk("reset_data", 64'({m_rdata, s_wdata}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;

    do_txn(1, 32'h8000_0010, 32'hA5A5_A5A5, 1, 1, 32'd0, 0, 0);
    do_txn(0, 32'h0000_0004, 32'h0, 3, 2, 32'h1234_5678, 0, 0);
    do_txn(0, 32'h0000_0020, 32'h0, 3, 2, 32'h0BAD_F00D, 2, 0);
    do_txn(1, 32'h8000_0030, 32'h1, 3, 1, 32'd0, 2, 0);
    do_txn(1, 32'h0000_0040, 32'h2, TO + 1, 1, 32'd0, 0, 0);
    do_txn(1, 32'h8000_0044, 32'h3, TO, 1, 32'd0, 0, 0);
    do_txn(0, 32'h0000_0048, 32'h0, 1, TO + 1, 32'h5555_AAAA, 1, 0);
    do_txn(0, 32'h8000_004C, 32'h0, 2, TO, 32'hCAFE_0001, 0, 0);
    do_txn(1, 32'h0000_0050, 32'h4, 2, 1, 32'd0, 0, 1);
    do_txn(1, 32'h8000_0054, 32'h5, 1, 1, 32'd0, 0, 0);
    reset_in_wresp();

    for (int n = 0; n < 200; n++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
             $urandom_range(1, TO + 2), $urandom_range(1, TO + 2), $urandom,
             $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    m_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
